// File: rtl/icache_assoc_pkg.sv
// -----------------------------------------------------------------------------
// icache_assoc_pkg
// Shared definitions for the set-associative instruction cache:
//   - refill FSM state encodings (2 bits)
//   - TRUE / FALSE constants
//   - default WAYS / SETS / LINE_WORDS
//   - address-slice width helpers (offset, index, tag, selector widths)
// Optional feature macro used by the cache: ICACHE_PERF_EN.
// -----------------------------------------------------------------------------
package icache_assoc_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_REFILL     = 2'd1;
  localparam logic [1:0] ST_WAIT_ABORT = 2'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DEF_WAYS       = 2;
  localparam int DEF_SETS       = 64;
  localparam int DEF_LINE_WORDS = 4;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  // Byte offset within a line: word select plus the two byte bits.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return ADDR_W - idx_w(sets) - off_w(line_words);
  endfunction

  // Selector width that never collapses to zero bits (n == 1 still gets 1 bit).
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// -----------------------------------------------------------------------------
// icache_assoc_if
// Bundles the IF-side fetch handshake and the MemCtrl word-read handshake.
//   rdy        global enable (low freezes the cache)
//   jp_wrong   branch mispredict, kills pending/next response
//   if_req/if_pc         fetch request and word-aligned address
//   if_valid/if_ins      one-cycle instruction response
//   mem_req/mem_addr     word read request, held until mem_valid
//   mem_valid/mem_data   returned word
// Modports: slave = the cache, master = the IF/MemCtrl environment.
// -----------------------------------------------------------------------------
interface icache_assoc_if;
  logic        rdy;
  logic        jp_wrong;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_ins;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport slave (
    input  rdy, jp_wrong, if_req, if_pc, mem_valid, mem_data,
    output if_valid, if_ins, mem_req, mem_addr
  );

  modport master (
    output rdy, jp_wrong, if_req, if_pc, mem_valid, mem_data,
    input  if_valid, if_ins, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_assoc_way.sv
// -----------------------------------------------------------------------------
// icache_assoc_way
// One way of the cache: valid[SETS], tag[SETS], data[SETS][LINE_WORDS].
// Ports:
//   clk, rst                 clock, async active-low reset (clears valid bits)
//   rd_idx, rd_tag, rd_word  combinational lookup -> hit, line_valid, rd_data
//   wr_en, wr_idx, wr_tag, wr_line   synchronous whole-line install
// -----------------------------------------------------------------------------
module icache_assoc_way
  import icache_assoc_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W     = idx_w(SETS),
  localparam int TAG_W     = tag_w(SETS, LINE_WORDS),
  localparam int CNT_W     = sel_w(LINE_WORDS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IDX_W-1:0]                  rd_idx,
  input  logic [TAG_W-1:0]                  rd_tag,
  input  logic [CNT_W-1:0]                  rd_word,
  output logic                              hit,
  output logic                              line_valid,
  output logic [WORD_W-1:0]                 rd_data,
  input  logic                              wr_en,
  input  logic [IDX_W-1:0]                  wr_idx,
  input  logic [TAG_W-1:0]                  wr_tag,
  input  logic [LINE_WORDS-1:0][WORD_W-1:0] wr_line
);

  logic [SETS-1:0]                  valid;
  logic [TAG_W-1:0]                 tag_mem  [SETS];
  logic [LINE_WORDS-1:0][WORD_W-1:0] data_mem [SETS];

  assign line_valid = valid[rd_idx];
  assign hit        = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data    = data_mem[rd_idx][rd_word];

  // NOTE: clocked state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= TRUE;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone gate hits,
  // which lets these arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// -----------------------------------------------------------------------------
// icache_assoc
// N-way set-associative instruction cache with multi-word lines between IF and
// MemCtrl. Hits respond the next cycle; misses refill a whole line word by word
// (words 0..LINE_WORDS-1 in order), install it, then the held request re-looks
// up and hits. jp_wrong aborts a refill without installing the line.
// Ports:
//   clk, rst   clock, async active-low reset
//   bus        icache_assoc_if.slave (rdy, jp_wrong, IF and MemCtrl handshakes)
//   perf_hit_cnt, perf_miss_cnt   lookup counters, only with ICACHE_PERF_EN
// -----------------------------------------------------------------------------
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int WAYS       = DEF_WAYS,
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  icache_assoc_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS, LINE_WORDS);
  localparam int CNT_W = sel_w(LINE_WORDS);
  localparam int WAY_W = sel_w(WAYS);

  logic [1:0]                        state;
  logic [TAG_W-1:0]                  fill_tag;
  logic [IDX_W-1:0]                  fill_idx;
  logic [CNT_W-1:0]                  cnt;
  logic [WAY_W-1:0]                  victim_q;
  logic [SETS-1:0][WAY_W-1:0]        rr_ptr;
  logic [LINE_WORDS-1:0][WORD_W-1:0] line_buf;
  logic [LINE_WORDS-1:0][WORD_W-1:0] fill_line;
  logic                              if_valid_q;
  logic [WORD_W-1:0]                 if_ins_q;

  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [CNT_W-1:0]  pc_word;
  logic [1:0]        unused_pc;
  logic [WAYS-1:0]   hit_vec;
  logic [WAYS-1:0]   valid_vec;
  logic [WORD_W-1:0] way_data [WAYS];
  logic              any_hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [WORD_W-1:0] hit_data;
  logic              lookup;
  logic              last_word;
  logic              install;
  logic [WAYS-1:0]   way_we;

  assign pc_tag    = bus.if_pc[ADDR_W-1 -: TAG_W];
  assign pc_idx    = bus.if_pc[OFF_W +: IDX_W];
  // Masking instead of slicing keeps LINE_WORDS == 1 legal (word select is 0).
  assign pc_word   = CNT_W'(bus.if_pc[ADDR_W-1:2] & 30'(LINE_WORDS - 1));
  assign unused_pc = bus.if_pc[1:0];

  assign lookup    = bus.rdy && (state == ST_IDLE) && bus.if_req && !bus.jp_wrong;
  assign last_word = (cnt == CNT_W'(LINE_WORDS - 1));
  // Install happens on the edge that accepts the final word, so the buffer is
  // bypassed for that word.
  assign install   = bus.rdy && (state == ST_REFILL) && bus.mem_valid &&
                     !bus.jp_wrong && last_word;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = install && (victim_q == WAY_W'(w));

    icache_assoc_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .rd_idx     (pc_idx),
      .rd_tag     (pc_tag),
      .rd_word    (pc_word),
      .hit        (hit_vec[w]),
      .line_valid (valid_vec[w]),
      .rd_data    (way_data[w]),
      .wr_en      (way_we[w]),
      .wr_idx     (fill_idx),
      .wr_tag     (fill_tag),
      .wr_line    (fill_line)
    );
  end

  // NOTE: combinational blocks assign defaults first with blocking '=' so no
  // path leaves a variable unassigned (no latch). The descending loop lets the
  // lowest matching way win for both the hit mux and the invalid-way victim.
  always_comb begin
    any_hit = |hit_vec;
    hit_way = '0;
    victim  = rr_ptr[pc_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])    hit_way = WAY_W'(w);
      if (!valid_vec[w]) victim  = WAY_W'(w);
    end
    hit_data = way_data[hit_way];
  end

  always_comb begin
    fill_line      = line_buf;
    fill_line[cnt] = bus.mem_data;
  end

  assign bus.mem_req  = (state != ST_IDLE);
  assign bus.mem_addr = bus.mem_req ?
                        ({fill_tag, fill_idx, {OFF_W{1'b0}}} | (ADDR_W'(cnt) << 2)) : '0;
  assign bus.if_valid = if_valid_q;
  assign bus.if_ins   = if_ins_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      fill_tag   <= '0;
      fill_idx   <= '0;
      cnt        <= '0;
      victim_q   <= '0;
      rr_ptr     <= '0;
      if_valid_q <= FALSE;
      if_ins_q   <= '0;
    end else if (bus.rdy) begin
      if_valid_q <= FALSE;
      case (state)
        ST_IDLE: begin
          if (lookup) begin
            if (any_hit) begin
              if_valid_q <= TRUE;
              if_ins_q   <= hit_data;
            end else begin
              fill_tag <= pc_tag;
              fill_idx <= pc_idx;
              victim_q <= victim;
              cnt      <= '0;
              state    <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (bus.mem_valid) begin
            if (bus.jp_wrong) begin
              // Word arriving with the mispredict is dropped; nothing pending.
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
              if (last_word) begin
                state            <= ST_IDLE;
                rr_ptr[fill_idx] <= (rr_ptr[fill_idx] == WAY_W'(WAYS - 1)) ?
                                    '0 : rr_ptr[fill_idx] + 1'b1;
              end
            end
          end else if (bus.jp_wrong) begin
            // MemCtrl cannot cancel: keep mem_req until the word returns.
            state <= ST_WAIT_ABORT;
          end
        end
        ST_WAIT_ABORT: begin
          if (bus.mem_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rdy && (state == ST_REFILL) && bus.mem_valid) begin
      line_buf[cnt] <= bus.mem_data;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (lookup) begin
      if (any_hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else         perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
